// File: rtl/cnn_pkg.sv
// Shared CNN datapath constants, width helpers and the accumulator FSM encoding.
package cnn_pkg;

  localparam int unsigned DEF_PWIDTH = 16;
  localparam int unsigned DEF_DWIDTH = 20;
  localparam int unsigned DEF_KSIZE  = 9;

  typedef enum logic {
    StIdle  = 1'b0,
    StAccum = 1'b1
  } accum_state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((64'(1) << result) < 64'(value)) begin
      result++;
    end
    return result;
  endfunction

  // Wide enough for KSIZE full-scale products plus a full-scale bias.
  function automatic int unsigned acc_width(input int unsigned pwidth,
                                            input int unsigned dwidth,
                                            input int unsigned ksize);
    int unsigned prod_sum_w;
    prod_sum_w = pwidth + clog2(ksize);
    return ((dwidth > prod_sum_w) ? dwidth : prod_sum_w) + 1;
  endfunction

endpackage

// File: rtl/relu_sat.sv
// Combinational requantiser: optional ReLU, then signed saturation from IN_W to OUT_W bits.
module relu_sat #(
  parameter int unsigned IN_W  = 21,
  parameter int unsigned OUT_W = 20
) (
  input  logic signed [IN_W-1:0]  sum_i,
  input  logic                    en_relu_i,
  output logic signed [OUT_W-1:0] result_o,
  output logic                    sat_o
);

  if (IN_W <= OUT_W) begin : g_width_check
    $error("relu_sat: IN_W must exceed OUT_W");
  end

  // In range only when every bit above the output sign bit matches it.
  logic [IN_W-OUT_W:0] top_bits;
  assign top_bits = sum_i[IN_W-1:OUT_W-1];

  always_comb begin
    result_o = sum_i[OUT_W-1:0];
    sat_o    = 1'b0;
    if (en_relu_i && sum_i[IN_W-1]) begin
      result_o = '0;
    end else if (!(&top_bits) && (|top_bits)) begin
      sat_o    = 1'b1;
      result_o = sum_i[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/conv_accum.sv
// Accumulates KSIZE signed products plus a per-window bias into one requantised result,
// emitted as a one-cycle valid strobe for the downstream pooling stage.
module conv_accum
  import cnn_pkg::*;
#(
  parameter int unsigned PWIDTH = DEF_PWIDTH,
  parameter int unsigned DWIDTH = DEF_DWIDTH,
  parameter int unsigned KSIZE  = DEF_KSIZE
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     en_relu,
  input  logic signed [PWIDTH-1:0] prod_in,
  input  logic signed [DWIDTH-1:0] bias_in,
  input  logic                     valid_in,
  output logic signed [DWIDTH-1:0] data_out,
  output logic                     valid_out,
  output logic                     sat_flag
);

  if (KSIZE < 2 || KSIZE > 256) begin : g_ksize_check
    $error("conv_accum: KSIZE must be in 2..256");
  end

  localparam int unsigned AccW = acc_width(PWIDTH, DWIDTH, KSIZE);
  localparam int unsigned CntW = clog2(KSIZE);

  accum_state_e              state_q, state_d;
  logic [CntW-1:0]           tap_cnt_q, tap_cnt_d;
  logic signed [AccW-1:0]    acc_q, acc_d;
  logic signed [DWIDTH-1:0]  data_q, data_d;
  logic                      valid_q, valid_d;
  logic                      sat_q, sat_d;

  logic signed [AccW-1:0]    prod_ext, bias_ext, sum;
  logic signed [DWIDTH-1:0]  rs_result;
  logic                      rs_sat;
  logic                      last_tap;

  assign prod_ext = {{(AccW-PWIDTH){prod_in[PWIDTH-1]}}, prod_in};
  assign bias_ext = {{(AccW-DWIDTH){bias_in[DWIDTH-1]}}, bias_in};
  assign sum      = acc_q + prod_ext;
  assign last_tap = (state_q == StAccum) && (tap_cnt_q == CntW'(KSIZE - 1));

  relu_sat #(
    .IN_W (AccW),
    .OUT_W(DWIDTH)
  ) u_relu_sat (
    .sum_i    (sum),
    .en_relu_i(en_relu),
    .result_o (rs_result),
    .sat_o    (rs_sat)
  );

  always_comb begin
    state_d   = state_q;
    tap_cnt_d = tap_cnt_q;
    acc_d     = acc_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    sat_d     = sat_q;
    if (clear) begin
      // Any tap presented alongside clear is dropped.
      state_d   = StIdle;
      tap_cnt_d = '0;
      acc_d     = '0;
      sat_d     = 1'b0;
    end else if (valid_in) begin
      unique case (state_q)
        StIdle: begin
          acc_d     = prod_ext + bias_ext;
          tap_cnt_d = CntW'(1);
          state_d   = StAccum;
        end
        StAccum: begin
          if (last_tap) begin
            data_d    = rs_result;
            valid_d   = 1'b1;
            sat_d     = sat_q | rs_sat;
            acc_d     = '0;
            tap_cnt_d = '0;
            state_d   = StIdle;
          end else begin
            acc_d     = sum;
            tap_cnt_d = tap_cnt_q + CntW'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      tap_cnt_q <= '0;
      acc_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      sat_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tap_cnt_q <= tap_cnt_d;
      acc_q     <= acc_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      sat_q     <= sat_d;
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign sat_flag  = sat_q;

endmodule

// File: tb/tb_conv_accum.sv
// Self-checking bench for conv_accum: directed table, multi-cycle corner sequences, random run.
module tb_conv_accum;

  localparam int unsigned PW = 16;
  localparam int unsigned DW = 20;
  localparam int unsigned K  = 9;
  localparam longint MaxV = (longint'(1) <<< (DW - 1)) - 1;
  localparam longint MinV = -(longint'(1) <<< (DW - 1));

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 clear = 1'b0;
  logic                 en_relu = 1'b0;
  logic                 valid_in = 1'b0;
  logic signed [PW-1:0] prod_in = '0;
  logic signed [DW-1:0] bias_in = '0;
  logic signed [DW-1:0] data_out;
  logic                 valid_out;
  logic                 sat_flag;

  always #5 clk = ~clk;

  conv_accum #(
    .PWIDTH(PW),
    .DWIDTH(DW),
    .KSIZE (K)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .en_relu  (en_relu),
    .prod_in  (prod_in),
    .bias_in  (bias_in),
    .valid_in (valid_in),
    .data_out (data_out),
    .valid_out(valid_out),
    .sat_flag (sat_flag)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: the open window is a queue of taps plus its bias.
  int     m_win[$];
  int     m_bias = 0;
  bit     m_valid = 1'b0;
  longint m_data = 0;
  bit     m_sat = 1'b0;

  int     cyc = 0;
  int     pulse_cyc[$];
  longint pulse_data[$];

  typedef struct {
    string name;
    int    bias;
    int    prod;
    bit    relu;
    int    exp_data;
    bit    exp_sat;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_win.delete();
    m_valid = 1'b0;
    m_data  = 0;
    m_sat   = 1'b0;
  endtask

  task automatic model_apply(input bit clr, input bit vld, input bit relu, input int prod,
                             input int bias);
    longint s;
    m_valid = 1'b0;
    if (clr) begin
      m_win.delete();
      m_sat = 1'b0;
    end else if (vld) begin
      if (m_win.size() == 0) m_bias = bias;
      m_win.push_back(prod);
      if (m_win.size() == K) begin
        s = m_bias;
        foreach (m_win[i]) s += m_win[i];
        if (relu && s < 0) m_data = 0;
        else if (s > MaxV) begin
          m_data = MaxV;
          m_sat  = 1'b1;
        end else if (s < MinV) begin
          m_data = MinV;
          m_sat  = 1'b1;
        end else m_data = s;
        m_valid = 1'b1;
        m_win.delete();
      end
    end
  endtask

  // Drive one cycle of inputs, advance one edge, compare all outputs to the model.
  task automatic step(input bit clr, input bit vld, input bit relu, input int prod,
                      input int bias);
    clear    = clr;
    valid_in = vld;
    en_relu  = relu;
    prod_in  = PW'(prod);
    bias_in  = DW'(bias);
    model_apply(clr, vld, relu, prod, bias);
    @(posedge clk);
    #1;
    cyc++;
    if (valid_out) begin
      pulse_cyc.push_back(cyc);
      pulse_data.push_back(longint'(data_out));
    end
    check("valid_out", longint'(valid_out), longint'(m_valid));
    check("data_out", longint'(data_out), m_data);
    check("sat_flag", longint'(sat_flag), longint'(m_sat));
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 1000000");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"basic",   5,       100,    1'b0, 905,     1'b0};
    vecs[1] = '{"relu_on", 0,       -100,   1'b1, 0,       1'b0};
    vecs[2] = '{"relu_off", 0,      -100,   1'b0, -900,    1'b0};
    vecs[3] = '{"sat_pos", 524287,  32767,  1'b0, 524287,  1'b1};
    vecs[4] = '{"sat_neg", -524288, -32768, 1'b0, -524288, 1'b1};

    // Reset state
    #2;
    check("reset_data", longint'(data_out), 0);
    check("reset_valid", longint'(valid_out), 0);
    check("reset_sat", longint'(sat_flag), 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Directed table: each row is a clean window of K identical taps.
    foreach (vecs[v]) begin
      step(1'b1, 1'b0, 1'b0, 0, 0);
      for (int t = 0; t < int'(K); t++) step(1'b0, 1'b1, vecs[v].relu, vecs[v].prod, vecs[v].bias);
      check({vecs[v].name, "_valid"}, longint'(valid_out), 1);
      check({vecs[v].name, "_data"}, longint'(data_out), vecs[v].exp_data);
      check({vecs[v].name, "_sat"}, longint'(sat_flag), longint'(vecs[v].exp_sat));
      idle();
      check({vecs[v].name, "_hold"}, longint'(data_out), vecs[v].exp_data);
    end

    // Gap inside a window, then a back-to-back second window.
    step(1'b1, 1'b0, 1'b0, 0, 0);
    pulse_cyc.delete();
    pulse_data.delete();
    for (int t = 1; t <= 4; t++) step(1'b0, 1'b1, 1'b0, t, 0);
    for (int g = 0; g < 3; g++) idle();
    for (int t = 5; t <= 9; t++) step(1'b0, 1'b1, 1'b0, t, 0);
    for (int t = 1; t <= 9; t++) step(1'b0, 1'b1, 1'b0, t, 0);
    idle();
    check("gap_pulses", longint'(pulse_cyc.size()), 2);
    if (pulse_cyc.size() == 2) begin
      check("gap_data0", pulse_data[0], 45);
      check("gap_data1", pulse_data[1], 45);
      check("gap_spacing", longint'(pulse_cyc[1] - pulse_cyc[0]), 9);
    end

    // Clear mid-window drops the partial sum and the coincident tap.
    pulse_cyc.delete();
    pulse_data.delete();
    for (int t = 0; t < 5; t++) step(1'b0, 1'b1, 1'b0, 50, 0);
    step(1'b1, 1'b1, 1'b0, 50, 0);
    for (int t = 0; t < int'(K); t++) step(1'b0, 1'b1, 1'b0, 10, 0);
    idle();
    check("clear_pulses", longint'(pulse_cyc.size()), 1);
    if (pulse_cyc.size() == 1) check("clear_data", pulse_data[0], 90);
    check("clear_sat", longint'(sat_flag), 0);

    // Async reset mid-window, after sat_flag has been set.
    for (int t = 0; t < int'(K); t++) step(1'b0, 1'b1, 1'b0, 32767, 524287);
    for (int t = 0; t < 4; t++) step(1'b0, 1'b1, 1'b0, 7, 3);
    #3;
    reset = 1'b0;
    #1;
    check("areset_data", longint'(data_out), 0);
    check("areset_valid", longint'(valid_out), 0);
    check("areset_sat", longint'(sat_flag), 0);
    model_reset();
    valid_in = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    pulse_cyc.delete();
    pulse_data.delete();
    for (int t = 0; t < int'(K); t++) step(1'b0, 1'b1, 1'b0, 7, 1);
    idle();
    check("areset_pulses", longint'(pulse_cyc.size()), 1);
    if (pulse_cyc.size() == 1) check("areset_window", pulse_data[0], 64);

    // Random traffic against the model; bias varies every cycle to exercise first-tap sampling.
    for (int n = 0; n < 3000; n++) begin
      int prod;
      int bias;
      prod = int'($urandom_range(0, 65535)) - 32768;
      bias = int'($urandom_range(0, 1048575)) - 524288;
      step(($urandom % 60) == 0, ($urandom % 4) != 0, 1'($urandom % 2), prod, bias);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_accum.md
Name: conv_accum

Overview:
- Sits between `mult` and `max_pool`. Accumulates KSIZE signed products from `mult` into one convolution-window sum.
- Adds a per-window bias, applies optional ReLU, and saturates to DWIDTH.
- Emits one result per window as a `data_in` / `valid_in` pair that `max_pool` consumes directly.

Parameters:
- PWIDTH, 16, signed product width from `mult` (WIDTH_A+WIDTH_B)
- DWIDTH, 20, signed output/bias width; matches `max_pool` DWIDTH
- KSIZE, 9, products per window (3x3 kernel); legal range 2..256

Ports:
- clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- clear  in  1  synchronous abort of the partial window
- en_relu  in  1  1 = clamp negative results to 0
- prod_in  in  PWIDTH  signed product from `mult`
- bias_in  in  DWIDTH  signed bias; sampled only on a window's first tap
- valid_in  in  1  prod_in valid this cycle
- data_out  out  DWIDTH  signed window result
- valid_out  out  1  one-cycle strobe, data_out valid
- sat_flag  out  1  sticky; set when any result saturated

Behaviour:
- Reset (reset==0, async):
  - data_out=0, valid_out=0, sat_flag=0.
  - tap_cnt=0, acc=0, state=IDLE.
  - Reset mid-window discards the partial sum; no valid_out follows.
- Internal accumulator width: ACC_W = max(DWIDTH, PWIDTH+clog2(KSIZE)) + 1. It never overflows internally; all extensions are sign extensions.
- FSM:
  - IDLE: tap_cnt==0, no partial sum.
  - ACCUM: 1 <= tap_cnt <= KSIZE-1.
- IDLE, valid_in=1, clear=0:
  - acc <= sext(prod_in) + sext(bias_in); tap_cnt <= 1; go to ACCUM.
- ACCUM, valid_in=1, tap_cnt<KSIZE-1:
  - acc <= acc + sext(prod_in); tap_cnt++.
- ACCUM, valid_in=1, tap_cnt==KSIZE-1 (last tap):
  - sum = acc + sext(prod_in).
  - Registered next edge: data_out <= relu_sat(sum), valid_out <= 1.
  - tap_cnt <= 0; return to IDLE.
- valid_in=0: acc, tap_cnt and state hold. Gaps of any length inside a window are legal.
- Latency: valid_out asserts exactly 1 cycle after the edge sampling the last tap.
- Back-to-back windows: a first tap may arrive on the cycle right after a last tap, giving no bubble. Sustained throughput is 1 result per KSIZE valid cycles.
- valid_out: high for exactly one cycle per completed window. data_out holds its last value while valid_out=0.
- relu_sat(sum):
  - If en_relu and sum<0, result = 0.
  - Else clamp to [-2^(DWIDTH-1), 2^(DWIDTH-1)-1].
  - sat_flag <= 1 when a clamp occurs. It clears only on reset or clear.
  - en_relu is sampled on the last-tap cycle.
- clear=1 (sync):
  - tap_cnt=0, acc=0, state=IDLE, sat_flag=0.
  - clear has priority over a simultaneous valid_in; that tap is dropped.
  - A valid_out already scheduled from the previous edge still appears.
- KSIZE==1 is not supported (ACCUM would be empty); elaboration-time check required.

Decomposition:
- Shared package cnn_pkg:
  - function acc_width(PWIDTH, DWIDTH, KSIZE)
  - clog2 helper
  - constants DEF_PWIDTH=16, DEF_DWIDTH=20, DEF_KSIZE=9, reused by `mult` and `max_pool` instances
  - FSM state encoding IDLE=1'b0, ACCUM=1'b1
- One sub-module: relu_sat. Combinational; parameters IN_W, OUT_W; inputs sum and en_relu; outputs result and sat. It is reusable at other requant points.

Test Plan:
- Basic window: KSIZE=9, bias_in=5, nine taps prod_in=100 consecutive, en_relu=0 -> one valid_out with data_out=905, one cycle after the 9th tap; sat_flag=0.
- ReLU: nine taps prod_in=-100, bias 0 -> en_relu=1 gives data_out=0; repeated with en_relu=0 gives data_out=-900.
- Saturation both ways:
  - bias=524287, nine taps 32767 -> data_out=524287, sat_flag=1.
  - bias=-524288, nine taps -32768 -> data_out=-524288.
- Gaps and back-to-back: taps 1..9 with valid_in low 3 cycles between taps 4 and 5, immediately followed by a second window of taps 1..9, bias 0 -> two valid_out pulses, both data_out=45. The second pulse comes exactly 9 valid cycles after the first; no pulse during the gap.
- clear mid-window: 5 taps of 50, then clear together with a valid tap, then a full window of 10, bias 0 -> only one valid_out, data_out=90; sat_flag=0.
- Async reset mid-window: 4 taps, then reset=0 between clock edges -> outputs 0 immediately. After release, a full window of 7s with bias 1 -> data_out=64.
